// File: rtl/mips_pkg.sv
// mips_pkg: shared state encodings, instruction field constants, control
// codes and the per-state Moore control table for the multicycle controller.
package mips_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_R     = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_HALT     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcWe;
    logic       irWe;
    logic       memRe;
    logic       memWe;
    logic       iord;
    logic       regWe;
    logic       regDst;
    logic       memToReg;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic [1:0] pcSrc;
    logic       instDone;
    logic       halted;
  } ctrl_t;

  // Input-independent control values for each state; BRANCH's PC write
  // enable and EXEC_R's ALU op are patched in by the top level.
  function automatic ctrl_t ctrlFor(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.memRe   = 1'b1;
        c.irWe    = 1'b1;
        c.aluSrcB = SRCB_FOUR;
        c.aluOp   = ALU_ADD;
        c.pcSrc   = PCSRC_ALU;
        c.pcWe    = 1'b1;
      end
      S_DECODE: begin
        c.aluSrcB = SRCB_IMM_SH2;
        c.aluOp   = ALU_ADD;
      end
      S_EXEC_R: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_REG;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_IMM;
        c.aluOp   = ALU_ADD;
      end
      S_WB_R: begin
        c.regWe    = 1'b1;
        c.regDst   = 1'b1;
        c.instDone = 1'b1;
      end
      S_WB_I: begin
        c.regWe    = 1'b1;
        c.instDone = 1'b1;
      end
      S_MEM_RD: begin
        c.memRe = 1'b1;
        c.iord  = 1'b1;
      end
      S_MEM_WB: begin
        c.regWe    = 1'b1;
        c.memToReg = 1'b1;
        c.instDone = 1'b1;
      end
      S_MEM_WR: begin
        c.memWe    = 1'b1;
        c.iord     = 1'b1;
        c.instDone = 1'b1;
      end
      S_BRANCH: begin
        c.aluSrcA  = 1'b1;
        c.aluSrcB  = SRCB_REG;
        c.aluOp    = ALU_SUB;
        c.pcSrc    = PCSRC_ALUOUT;
        c.instDone = 1'b1;
      end
      S_JUMP: begin
        c.pcSrc    = PCSRC_JUMP;
        c.pcWe     = 1'b1;
        c.instDone = 1'b1;
      end
      S_HALT: begin
        c.halted = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// mips_alu_dec: maps an R-type FUNCT field to an ALU operation and flags
// function codes the controller does not implement.
module mips_alu_dec
  import mips_pkg::*;
(
  input  logic [5:0] FUNCT,
  output logic [2:0] ALU_OP,
  output logic       LEGAL
);

  // FUNCT to ALU operation lookup
  always_comb begin
    ALU_OP = ALU_ADD;
    LEGAL  = 1'b1;
    case (FUNCT)
      FN_ADD:  ALU_OP = ALU_ADD;
      FN_SUB:  ALU_OP = ALU_SUB;
      FN_AND:  ALU_OP = ALU_AND;
      FN_OR:   ALU_OP = ALU_OR;
      FN_SLT:  ALU_OP = ALU_SLT;
      default: LEGAL  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle MIPS control unit with free-run and single-step
// modes and a sticky halt on illegal instructions.
module mips_mc_ctrl
  import mips_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       RUN,
  input  logic       STEP,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       ZERO,
  output logic       PC_WE,
  output logic       IR_WE,
  output logic       MEM_RE,
  output logic       MEM_WE,
  output logic       IORD,
  output logic       REG_WE,
  output logic       REG_DST,
  output logic       MEM_TO_REG,
  output logic       ALU_SRC_A,
  output logic [1:0] ALU_SRC_B,
  output logic [2:0] ALU_OP,
  output logic [1:0] PC_SRC,
  output logic       INST_DONE,
  output logic       HALTED,
  output logic [3:0] STATE
);

  state_t     r_state;
  ctrl_t      r_ctrl;
  state_t     w_next;
  logic [2:0] w_functAluOp;
  logic       w_functLegal;

  mips_alu_dec u_aluDec (
    .FUNCT  (FUNCT),
    .ALU_OP (w_functAluOp),
    .LEGAL  (w_functLegal)
  );

  // Next-state selection; terminal states sample RUN to continue or rest
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (RUN || STEP) w_next = S_FETCH;
      S_FETCH:    w_next = S_DECODE;
      S_DECODE: begin
        case (OPCODE)
          OP_RTYPE:     w_next = S_EXEC_R;
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_EXEC_I;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_HALT;
        endcase
      end
      S_EXEC_R:   w_next = w_functLegal ? S_WB_R : S_HALT;
      S_EXEC_I:   w_next = S_WB_I;
      S_MEM_ADDR: w_next = (OPCODE == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next = S_MEM_WB;
      S_WB_R, S_WB_I, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP:
                  w_next = RUN ? S_FETCH : S_IDLE;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_IDLE;
    endcase
  end

  // State register with controls registered from the state being entered
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= ctrlFor(w_next);
    end
  end

  assign PC_WE      = (r_state == S_BRANCH) ? ZERO : r_ctrl.pcWe;
  assign ALU_OP     = (r_state == S_EXEC_R) ? w_functAluOp : r_ctrl.aluOp;
  assign IR_WE      = r_ctrl.irWe;
  assign MEM_RE     = r_ctrl.memRe;
  assign MEM_WE     = r_ctrl.memWe;
  assign IORD       = r_ctrl.iord;
  assign REG_WE     = r_ctrl.regWe;
  assign REG_DST    = r_ctrl.regDst;
  assign MEM_TO_REG = r_ctrl.memToReg;
  assign ALU_SRC_A  = r_ctrl.aluSrcA;
  assign ALU_SRC_B  = r_ctrl.aluSrcB;
  assign PC_SRC     = r_ctrl.pcSrc;
  assign INST_DONE  = r_ctrl.instDone;
  assign HALTED     = r_ctrl.halted;
  assign STATE      = r_state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: directed and randomized checks of the multicycle controller
// against an instruction-level reference model.
module tb_mips_mc_ctrl
  import mips_pkg::*;
;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RUN = 1'b0;
  logic       STEP = 1'b0;
  logic [5:0] OPCODE = 6'h00;
  logic [5:0] FUNCT = 6'h20;
  logic       ZERO = 1'b0;
  logic       PC_WE, IR_WE, MEM_RE, MEM_WE, IORD, REG_WE, REG_DST, MEM_TO_REG;
  logic       ALU_SRC_A, INST_DONE, HALTED;
  logic [1:0] ALU_SRC_B, PC_SRC;
  logic [2:0] ALU_OP;
  logic [3:0] STATE;

  int errors = 0;
  int checks = 0;

  localparam logic [5:0] OP_LIST [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
  localparam logic [5:0] FN_LIST [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  mips_mc_ctrl dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .STEP(STEP), .OPCODE(OPCODE),
    .FUNCT(FUNCT), .ZERO(ZERO), .PC_WE(PC_WE), .IR_WE(IR_WE),
    .MEM_RE(MEM_RE), .MEM_WE(MEM_WE), .IORD(IORD), .REG_WE(REG_WE),
    .REG_DST(REG_DST), .MEM_TO_REG(MEM_TO_REG), .ALU_SRC_A(ALU_SRC_A),
    .ALU_SRC_B(ALU_SRC_B), .ALU_OP(ALU_OP), .PC_SRC(PC_SRC),
    .INST_DONE(INST_DONE), .HALTED(HALTED), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  // Advance one clock and settle just past the rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Every output packed into one word for whole-state comparison
  function automatic logic [21:0] obsVec();
    return {PC_WE, IR_WE, MEM_RE, MEM_WE, IORD, REG_WE, REG_DST, MEM_TO_REG,
            ALU_SRC_A, ALU_SRC_B, ALU_OP, PC_SRC, INST_DONE, HALTED, STATE};
  endfunction

  function automatic logic functOk(input logic [5:0] fn);
    return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A;
  endfunction

  function automatic logic [2:0] aluOfFunct(input logic [5:0] fn);
    case (fn)
      6'h22:   return 3'b001;
      6'h24:   return 3'b010;
      6'h25:   return 3'b011;
      6'h2A:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Phase k of an instruction, counting FETCH as phase 0
  function automatic logic [3:0] pathState(input logic [5:0] op, input logic [5:0] fn, input int k);
    logic [3:0] seq [5];
    seq[0] = S_FETCH; seq[1] = S_DECODE; seq[2] = S_HALT; seq[3] = S_HALT; seq[4] = S_HALT;
    case (op)
      6'h00: begin seq[2] = S_EXEC_R; seq[3] = functOk(fn) ? S_WB_R : S_HALT; end
      6'h23: begin seq[2] = S_MEM_ADDR; seq[3] = S_MEM_RD; seq[4] = S_MEM_WB; end
      6'h2B: begin seq[2] = S_MEM_ADDR; seq[3] = S_MEM_WR; end
      6'h04: seq[2] = S_BRANCH;
      6'h08: begin seq[2] = S_EXEC_I; seq[3] = S_WB_I; end
      6'h02: seq[2] = S_JUMP;
      default: ;
    endcase
    return seq[k];
  endfunction

  // Number of phases from FETCH through the terminal (or HALT) state
  function automatic int pathLen(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00:        return 4;
      6'h23:        return 5;
      6'h2B, 6'h08: return 4;
      6'h04, 6'h02: return 3;
      default:      return 3;
    endcase
    if (fn == 6'h3F) return 0;
  endfunction

  // Expected output word for a state, written straight from the control table
  function automatic logic [21:0] expVec(input logic [3:0] st, input logic z, input logic [5:0] fn);
    logic pcWe, irWe, memRe, memWe, iord, regWe, regDst, memToReg, srcA, done, halted;
    logic [1:0] srcB, pcSrc;
    logic [2:0] aluOp;
    {pcWe, irWe, memRe, memWe, iord, regWe, regDst, memToReg, srcA, done, halted} = '0;
    srcB = 2'b00; pcSrc = 2'b00; aluOp = 3'b000;
    case (st)
      S_FETCH:    begin memRe = 1; irWe = 1; srcB = 2'b01; pcWe = 1; end
      S_DECODE:   srcB = 2'b11;
      S_EXEC_R:   begin srcA = 1; aluOp = aluOfFunct(fn); end
      S_EXEC_I:   begin srcA = 1; srcB = 2'b10; end
      S_MEM_ADDR: begin srcA = 1; srcB = 2'b10; end
      S_WB_R:     begin regWe = 1; regDst = 1; done = 1; end
      S_WB_I:     begin regWe = 1; done = 1; end
      S_MEM_RD:   begin memRe = 1; iord = 1; end
      S_MEM_WB:   begin regWe = 1; memToReg = 1; done = 1; end
      S_MEM_WR:   begin memWe = 1; iord = 1; done = 1; end
      S_BRANCH:   begin srcA = 1; aluOp = 3'b001; pcSrc = 2'b01; pcWe = z; done = 1; end
      S_JUMP:     begin pcSrc = 2'b10; pcWe = 1; done = 1; end
      S_HALT:     halted = 1;
      default:    ;
    endcase
    return {pcWe, irWe, memRe, memWe, iord, regWe, regDst, memToReg,
            srcA, srcB, aluOp, pcSrc, done, halted, st};
  endfunction

  // Bring the controller back to IDLE with all controls quiet
  task automatic doReset();
    RST = 1'b0; RUN = 1'b0; STEP = 1'b0;
    tick();
    tick();
    RST = 1'b1;
  endtask

  // Reset holds IDLE with every output at zero, first edge after release moves
  task automatic test_reset();
    RST = 1'b0; RUN = 1'b1;
    tick();
    checks++;
    if (obsVec() !== expVec(S_IDLE, 1'b0, 6'h0)) begin
      errors++; $display("[TB] FAIL reset_idle: got %h want %h", obsVec(), expVec(S_IDLE, 1'b0, 6'h0));
    end
    tick();
    checks++;
    if (obsVec() !== expVec(S_IDLE, 1'b0, 6'h0)) begin
      errors++; $display("[TB] FAIL reset_hold: got %h want %h", obsVec(), expVec(S_IDLE, 1'b0, 6'h0));
    end
    RST = 1'b1;
    tick();
    checks++;
    if (STATE !== S_FETCH) begin
      errors++; $display("[TB] FAIL reset_first_edge: state %0d want %0d", STATE, S_FETCH);
    end
    doReset();
  endtask

  // Free-running add: four phases, back into FETCH, one INST_DONE
  task automatic test_rtype();
    int doneCount;
    doneCount = 0;
    OPCODE = 6'h00; FUNCT = 6'h20; RUN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      doneCount += INST_DONE;
      checks++;
      if (obsVec() !== expVec(pathState(6'h00, 6'h20, k), ZERO, 6'h20)) begin
        errors++; $display("[TB] FAIL rtype_phase%0d: got %h want %h", k, obsVec(), expVec(pathState(6'h00, 6'h20, k), ZERO, 6'h20));
      end
    end
    tick();
    doneCount += INST_DONE;
    checks++;
    if (STATE !== S_FETCH || doneCount != 1) begin
      errors++; $display("[TB] FAIL rtype_refetch: state %0d done %0d want state %0d done 1", STATE, doneCount, S_FETCH);
    end
    doReset();
  endtask

  // Single-stepped lw, with a STEP during the terminal state that must be ignored
  task automatic test_lw_step();
    OPCODE = 6'h23; FUNCT = 6'h00; RUN = 1'b0; STEP = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      STEP = (k == 4);
      checks++;
      if (obsVec() !== expVec(pathState(6'h23, 6'h00, k), ZERO, 6'h00)) begin
        errors++; $display("[TB] FAIL lw_phase%0d: got %h want %h", k, obsVec(), expVec(pathState(6'h23, 6'h00, k), ZERO, 6'h00));
      end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      STEP = 1'b0;
      checks++;
      if (obsVec() !== expVec(S_IDLE, 1'b0, 6'h0)) begin
        errors++; $display("[TB] FAIL lw_rest%0d: got %h want %h", k, obsVec(), expVec(S_IDLE, 1'b0, 6'h0));
      end
    end
    doReset();
  endtask

  // beq taken and not taken, both three phases long
  task automatic test_branch();
    for (int z = 0; z < 2; z++) begin
      OPCODE = 6'h04; ZERO = z[0]; STEP = 1'b1;
      for (int k = 0; k < 3; k++) begin
        tick();
        STEP = 1'b0;
        checks++;
        if (obsVec() !== expVec(pathState(6'h04, 6'h0, k), z[0], 6'h0)) begin
          errors++; $display("[TB] FAIL beq_z%0d_phase%0d: got %h want %h", z, k, obsVec(), expVec(pathState(6'h04, 6'h0, k), z[0], 6'h0));
        end
      end
      checks++;
      if (PC_WE !== z[0] || PC_SRC !== 2'b01) begin
        errors++; $display("[TB] FAIL beq_pcwe_z%0d: pc_we %b pc_src %b want %b 01", z, PC_WE, PC_SRC, z[0]);
      end
      tick();
      checks++;
      if (STATE !== S_IDLE) begin
        errors++; $display("[TB] FAIL beq_end_z%0d: state %0d want %0d", z, STATE, S_IDLE);
      end
    end
    ZERO = 1'b0;
    doReset();
  endtask

  // Illegal opcode and illegal funct both stick in HALT until reset
  task automatic test_halt();
    logic [5:0] op, fn;
    for (int c = 0; c < 2; c++) begin
      op = (c == 0) ? 6'h3F : 6'h00;
      fn = (c == 0) ? 6'h20 : 6'h00;
      OPCODE = op; FUNCT = fn; STEP = 1'b1;
      for (int k = 0; k < pathLen(op, fn); k++) begin
        tick();
        STEP = 1'b0;
        checks++;
        if (STATE !== pathState(op, fn, k)) begin
          errors++; $display("[TB] FAIL halt%0d_phase%0d: state %0d want %0d", c, k, STATE, pathState(op, fn, k));
        end
      end
      for (int k = 0; k < 4; k++) begin
        RUN = k[0]; STEP = ~k[0];
        tick();
        checks++;
        if (obsVec() !== expVec(S_HALT, 1'b0, fn)) begin
          errors++; $display("[TB] FAIL halt%0d_sticky%0d: got %h want %h", c, k, obsVec(), expVec(S_HALT, 1'b0, fn));
        end
      end
      RUN = 1'b0; STEP = 1'b0;
      #2 RST = 1'b0;
      #1;
      checks++;
      if (obsVec() !== expVec(S_IDLE, 1'b0, 6'h0)) begin
        errors++; $display("[TB] FAIL halt%0d_reset: got %h want %h", c, obsVec(), expVec(S_IDLE, 1'b0, 6'h0));
      end
      tick();
      RST = 1'b1;
    end
    FUNCT = 6'h20;
  endtask

  // Asynchronous reset during MEM_RD, then restart on the first edge
  task automatic test_reset_midinst();
    OPCODE = 6'h23; RUN = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (STATE !== S_MEM_RD) begin
      errors++; $display("[TB] FAIL midrst_reach: state %0d want %0d", STATE, S_MEM_RD);
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if (obsVec() !== expVec(S_IDLE, 1'b0, 6'h0)) begin
      errors++; $display("[TB] FAIL midrst_async: got %h want %h", obsVec(), expVec(S_IDLE, 1'b0, 6'h0));
    end
    tick();
    checks++;
    if (obsVec() !== expVec(S_IDLE, 1'b0, 6'h0)) begin
      errors++; $display("[TB] FAIL midrst_hold: got %h want %h", obsVec(), expVec(S_IDLE, 1'b0, 6'h0));
    end
    RST = 1'b1;
    tick();
    checks++;
    if (obsVec() !== expVec(S_FETCH, 1'b0, FUNCT)) begin
      errors++; $display("[TB] FAIL midrst_restart: got %h want %h", obsVec(), expVec(S_FETCH, 1'b0, FUNCT));
    end
    doReset();
  endtask

  // RUN dropped in EXEC_I finishes addi then rests; STEP in DECODE does nothing
  task automatic test_run_drop();
    OPCODE = 6'h08; RUN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      STEP = (k == 1);
      if (k == 2) RUN = 1'b0;
      checks++;
      if (obsVec() !== expVec(pathState(6'h08, 6'h0, k), ZERO, FUNCT)) begin
        errors++; $display("[TB] FAIL rundrop_phase%0d: got %h want %h", k, obsVec(), expVec(pathState(6'h08, 6'h0, k), ZERO, FUNCT));
      end
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (obsVec() !== expVec(S_IDLE, 1'b0, 6'h0)) begin
        errors++; $display("[TB] FAIL rundrop_rest%0d: got %h want %h", k, obsVec(), expVec(S_IDLE, 1'b0, 6'h0));
      end
    end
    doReset();
  endtask

  // Random legal instruction stream mixing free-run and single-step
  task automatic test_random();
    logic inIdle, runBit, z;
    logic [5:0] op, fn;
    int len;
    inIdle = 1'b1;
    for (int n = 0; n < 60; n++) begin
      op = OP_LIST[$urandom_range(0, 5)];
      fn = FN_LIST[$urandom_range(0, 4)];
      z = 1'($urandom_range(0, 1));
      runBit = 1'($urandom_range(0, 1));
      len = pathLen(op, fn);
      OPCODE = op; FUNCT = fn; ZERO = z;
      if (inIdle) begin
        RUN = runBit; STEP = ~runBit;
      end
      for (int k = 0; k < len; k++) begin
        tick();
        RUN = runBit;
        STEP = 1'($urandom_range(0, 1));
        checks++;
        if (obsVec() !== expVec(pathState(op, fn, k), z, fn)) begin
          errors++; $display("[TB] FAIL rand%0d_phase%0d op %h fn %h: got %h want %h", n, k, op, fn, obsVec(), expVec(pathState(op, fn, k), z, fn));
        end
      end
      inIdle = ~runBit;
      if (inIdle) begin
        tick();
        checks++;
        if (obsVec() !== expVec(S_IDLE, 1'b0, 6'h0)) begin
          errors++; $display("[TB] FAIL rand%0d_idle: got %h want %h", n, obsVec(), expVec(S_IDLE, 1'b0, 6'h0));
        end
      end
    end
    doReset();
  endtask

  initial begin
    #1;
    test_reset();
    test_rtype();
    test_lw_step();
    test_branch();
    test_halt();
    test_reset_midinst();
    test_run_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
